// File: rtl/sm_dip_input_pkg.sv
// Shared constants for the DIP switch input conditioner.
// The switch width is shared with the CPU dipValue input.
package sm_dip_input_pkg;

  localparam int SM_DIP_WIDTH            = 8;
  localparam int SM_DIP_DEBOUNCE_DEFAULT = 50000;

endpackage : sm_dip_input_pkg

// File: rtl/sm_debounce_bit.sv
// One DIP switch bit: two-flop synchronizer, debounce counter, output flop.
// Build option: SM_DIP_DEBOUNCE_EN. When undefined, no counter is built and
// the output follows the synchronized input one edge later (same as N=1).
module sm_debounce_bit
  import sm_dip_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SM_DIP_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic upd,
  output logic idle
);

  logic r_s1;
  logic r_s2;
  logic r_out;
  logic r_upd;
  logic w_upd;
  logic w_idle;

  // Two back-to-back flops bring the asynchronous switch line into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

`ifdef SM_DIP_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Update when the input has disagreed for the full window; idle when quiet.
  always_comb begin
    w_upd  = 1'b0;
    w_idle = 1'b0;
    if ((r_s2 != r_out) && (r_cnt == LP_LAST)) begin
      w_upd = 1'b1;
    end else begin
      w_upd = 1'b0;
    end
    w_idle = (r_cnt == '0) && (r_s2 == r_out);
  end

  // Count consecutive disagreeing cycles; any agreement or an update clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_s2 == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  // Debounce parameters have no effect in this build; keep them referenced.
  if ((DEBOUNCE_CYCLES < 1) || (CNT_W < 1)) begin : g_cfg_ignored
  end

  // Without a counter the output simply tracks the synchronized input.
  always_comb begin
    w_upd  = 1'b0;
    w_idle = 1'b0;
    if (r_s2 != r_out) begin
      w_upd = 1'b1;
    end else begin
      w_upd = 1'b0;
    end
    w_idle = (r_s2 == r_out);
  end
`endif

  // Output flop takes the new level on an update; upd marks that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 1'b0;
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_upd;
      if (w_upd) begin
        r_out <= r_s2;
      end
    end
  end

  assign out  = r_out;
  assign upd  = r_upd;
  assign idle = w_idle;

endmodule : sm_debounce_bit

// File: rtl/sm_dip_input.sv
// DIP switch input conditioner: per-bit sync and debounce feeding the CPU
// dipValue input, plus a change pulse and an all-settled flag.
// Build option: SM_DIP_DEBOUNCE_EN enables the debounce counters.
module sm_dip_input
  import sm_dip_input_pkg::*;
#(
  parameter int WIDTH           = SM_DIP_WIDTH,
  parameter int DEBOUNCE_CYCLES = SM_DIP_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dipRaw,
  output logic [WIDTH-1:0] dipValue,
  output logic             dipChanged,
  output logic             dipStable
);

  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_idle;
  logic             r_changed;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sm_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .raw (dipRaw[gi]),
      .out (dipValue[gi]),
      .upd (w_upd[gi]),
      .idle(w_idle[gi])
    );
  end

  // One pulse per edge on which any bit updated, regardless of how many did.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_upd;
    end
  end

  assign dipChanged = r_changed;
  assign dipStable  = &w_idle;

endmodule : sm_dip_input

// File: tb/tb_sm_dip_input.sv
// Self-checking bench for sm_dip_input with DEBOUNCE_CYCLES=4.
module tb_sm_dip_input;

  localparam int N = 4;
`ifdef SM_DIP_DEBOUNCE_EN
  localparam int NE = N;
`else
  localparam int NE = 1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] dipRaw;
  logic [7:0] dipValue;
  logic       dipChanged;
  logic       dipStable;

  int total;
  int bad;
  int pulses;
  int e;

  sm_dip_input #(.WIDTH(8), .DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .dipRaw    (dipRaw),
    .dipValue  (dipValue),
    .dipChanged(dipChanged),
    .dipStable (dipStable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output bit flips when the last NE synchronized samples since reset all
  // disagree with it; the change flag is that event seen one cycle later.
  logic        cap_rst;
  logic [7:0]  cap_raw;
  logic [7:0]  m_s1, m_s2, m_val;
  logic        m_chg, m_pend;
  logic [63:0] hist [8];
  int          nvalid;
  bit          started;

  always @(posedge clk) begin
    cap_rst <= rst;
    cap_raw <= dipRaw;
  end

  initial begin
    logic [7:0] upd;
    logic       all_diff;
    logic       exp_stable;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (cap_rst === 1'b1) begin
        m_s1 = 8'h00; m_s2 = 8'h00; m_val = 8'h00;
        m_chg = 1'b0; m_pend = 1'b0; nvalid = 0;
        for (int i = 0; i < 8; i++) hist[i] = 64'h0;
        started = 1'b1;
      end else if (started) begin
        for (int i = 0; i < 8; i++) hist[i] = {hist[i][62:0], m_s2[i]};
        if (nvalid < 64) nvalid++;
        upd = 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (nvalid >= NE) begin
            all_diff = 1'b1;
            for (int j = 0; j < NE; j++) if (hist[i][j] == m_val[i]) all_diff = 1'b0;
            upd[i] = all_diff;
          end
        end
        m_chg  = m_pend;
        m_pend = |upd;
        m_val  = m_val ^ upd;
        m_s2   = m_s1;
        m_s1   = cap_raw;
      end
      if (started) begin
        exp_stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (m_s2[i] != m_val[i]) exp_stable = 1'b0;
          if ((nvalid > 0) && (hist[i][0] != m_val[i])) exp_stable = 1'b0;
        end
        chk("model_value",   32'(dipValue),   32'(m_val));
        chk("model_changed", 32'(dipChanged), 32'(m_chg));
        chk("model_stable",  32'(dipStable),  32'(exp_stable));
        if (dipChanged === 1'b1) pulses++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic go_to(input int k);
    while (e <= k) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic settle(input logic [7:0] v);
    dipRaw = v;
    repeat (2 * NE + 8) @(negedge clk);
  endtask

  initial begin
    int p0;
    total = 0; bad = 0; pulses = 0; e = 0;
    rst = 1'b1;
    dipRaw = 8'hFF;

    // 1: reset holds everything at zero, release brings in FF
    repeat (3) @(negedge clk);
    chk("rst_value",   32'(dipValue),   32'h00);
    chk("rst_changed", 32'(dipChanged), 32'h0);
    chk("rst_stable",  32'(dipStable),  32'h1);
    rst = 1'b0; e = 0;
    go_to(NE);     chk("rel_value_before", 32'(dipValue), 32'h00);
    go_to(NE + 1); chk("rel_value_after",  32'(dipValue), 32'hFF);
    go_to(NE + 2); chk("rel_pulse",        32'(dipChanged), 32'h1);
    go_to(NE + 3); chk("rel_pulse_end",    32'(dipChanged), 32'h0);

    // 2: clean step 00 -> A5
    settle(8'h00);
    dipRaw = 8'hA5; e = 0;
    go_to(1);      chk("step_unstable",  32'(dipStable), 32'h0);
    go_to(NE);     chk("step_before",    32'(dipValue),  32'h00);
                   chk("step_busy",      32'(dipStable), 32'h0);
    go_to(NE + 1); chk("step_value",     32'(dipValue),  32'hA5);
    go_to(NE + 2); chk("step_pulse",     32'(dipChanged), 32'h1);
    go_to(NE + 3); chk("step_pulse_end", 32'(dipChanged), 32'h0);
                   chk("step_stable",    32'(dipStable), 32'h1);

    // 3: three-cycle glitch on bit 0
    settle(8'h00);
    p0 = pulses;
    dipRaw = 8'h01; e = 0;
    go_to(2);
    dipRaw = 8'h00;
    go_to(15);
    chk("glitch_value",  32'(dipValue),  32'h00);
    chk("glitch_stable", 32'(dipStable), 32'h1);
    chk("glitch_pulses", 32'(pulses - p0), (NE > 3) ? 32'd0 : 32'd2);

    // 4: bounce on bit 3 then hold high
    settle(8'h00);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      dipRaw = (i % 2 == 0) ? 8'h08 : 8'h00;
      @(negedge clk);
    end
    dipRaw = 8'h08; e = 0;
    go_to(NE);     chk("bounce_before", 32'(dipValue), 32'h00);
    go_to(NE + 1); chk("bounce_value",  32'(dipValue), 32'h08);
    go_to(NE + 6); chk("bounce_pulses", 32'(pulses - p0), (NE > 1) ? 32'd1 : 32'd5);

    // 5: staggered bits 1 and 6
    settle(8'h00);
    p0 = pulses;
    dipRaw = 8'h02; e = 0;
    go_to(1);      chk("stag_start", 32'(dipValue), 32'h00);
    dipRaw = 8'h42;
    go_to(NE + 1); chk("stag_first",  32'(dipValue), 32'h02);
    go_to(NE + 2); chk("stag_hold",   32'(dipValue), 32'h02);
    go_to(NE + 3); chk("stag_second", 32'(dipValue), 32'h42);
    go_to(NE + 8); chk("stag_pulses", 32'(pulses - p0), 32'd2);

    // 6: reset during a count, sampled at edges 3 and 4
    settle(8'h00);
    dipRaw = 8'h01; e = 0;
    go_to(2);      chk("midrst_pre", 32'(dipValue), (NE > 1) ? 32'h00 : 32'h01);
    rst = 1'b1;
    go_to(4);      chk("midrst_value",   32'(dipValue),   32'h00);
                   chk("midrst_changed", 32'(dipChanged), 32'h0);
                   chk("midrst_stable",  32'(dipStable),  32'h1);
    rst = 1'b0;
    go_to(NE + 5); chk("midrst_before", 32'(dipValue), 32'h00);
    go_to(NE + 6); chk("midrst_after",  32'(dipValue), 32'h01);
    go_to(NE + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sm_dip_input
